// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, plus single-cycle
// rise/fall pulses taken against one further registered copy of the level.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b0
) (
  input  logic clk,
  input  logic resetq,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync_q <= {STAGES{IDLE}};
      prev_q <= IDLE;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target for the j1 IO space: MSB-first bytes, sample on sck rise,
// shift on sck fall. CPU side uses the UART-style wr/rd strobes with busy/valid.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL        = 8'hFF
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       wr,
  input  logic       rd,
  input  logic       clr,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       busy,
  output logic       overrun,
  output logic       underrun,
  output logic       selected
);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_level_unused, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sck (
    .clk(clk), .resetq(resetq), .pin_i(sck),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_cs (
    .clk(clk), .resetq(resetq), .pin_i(cs_n),
    .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_mosi (
    .clk(clk), .resetq(resetq), .pin_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic       selected_q, selected_d;
  logic       miso_q, miso_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;

  // A cs rise in the same cycle as an sck edge ends the frame; the edge is dropped.
  logic       load, shift, sample, byte_done;
  logic [7:0] rx_byte, tx_load;

  assign load      = cs_fall | (sck_fall & selected_q & ~cs_rise & (bit_cnt_q == 3'd0));
  assign shift     = sck_fall & selected_q & ~cs_rise & (bit_cnt_q != 3'd0);
  assign sample    = sck_rise & selected_q & ~cs_rise;
  assign byte_done = sample & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q[6:0], mosi_s};

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      selected_q <= 1'b0;
      miso_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      tx_hold_q  <= 8'h00;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      selected_q <= selected_d;
      miso_q     <= miso_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_hold_q  <= tx_hold_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    selected_d = selected_q;
    miso_d     = miso_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_hold_d  = tx_hold_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    tx_load    = FILL;

    // Clears go first so a flag raised in the same cycle overrides them.
    if (clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end

    if (cs_fall) begin
      selected_d = 1'b1;
    end else if (cs_rise) begin
      selected_d = 1'b0;
    end

    // load and wr both look at the old busy, so they never contend for it.
    if (load) begin
      if (busy_q) begin
        tx_load = tx_hold_q;
        busy_d  = 1'b0;
      end else begin
        tx_load    = FILL;
        underrun_d = 1'b1;
      end
      tx_shift_d = tx_load;
      miso_d     = tx_load[7];
    end else if (shift) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
      miso_d     = tx_shift_q[6];
    end

    if (wr && !busy_q) begin
      tx_hold_d = tx_data;
      busy_d    = 1'b1;
    end

    if (cs_rise) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
      miso_d     = 1'b0;
    end else if (sample) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end

    if (byte_done) begin
      rx_data_d = rx_byte;
      valid_d   = 1'b1;
      if (valid_q) overrun_d = 1'b1;
    end else if (rd) begin
      valid_d = 1'b0;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = selected_q;
  assign selected = selected_q;
  assign rx_data  = rx_data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule
